// File: rtl/cmd_pkg.sv
// Shared definitions for the command responder: FSM states, frame layout,
// command indices, response types and response-frame assembly.
package cmd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DECODE  = 2'd1,
    ST_DELAY   = 2'd2,
    ST_RESPOND = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    RESP_NONE = 2'd0,
    RESP_R1   = 2'd1,
    RESP_R2   = 2'd2,
    RESP_R3   = 2'd3
  } resp_t;

  localparam int START_MSB = 39;
  localparam int START_LSB = 38;
  localparam int INDEX_MSB = 37;
  localparam int INDEX_LSB = 32;
  localparam int ARG_MSB   = 31;
  localparam int ARG_LSB   = 0;

  localparam logic [1:0] START_TX_OK = 2'b01;
  localparam logic [5:0] R2_RESERVED = 6'h3F;
  localparam logic [7:0] END_BYTE    = 8'h01;

  localparam logic [5:0] CMD0  = 6'd0;
  localparam logic [5:0] CMD2  = 6'd2;
  localparam logic [5:0] CMD4  = 6'd4;
  localparam logic [5:0] CMD9  = 6'd9;
  localparam logic [5:0] CMD10 = 6'd10;
  localparam logic [5:0] CMD15 = 6'd15;
  localparam logic [5:0] CMD41 = 6'd41;

  function automatic resp_t resp_type_of(input logic [5:0] idx);
    case (idx)
      CMD0, CMD4, CMD15: return RESP_NONE;
      CMD2, CMD9, CMD10: return RESP_R2;
      CMD41:             return RESP_R3;
      default:           return RESP_R1;
    endcase
  endfunction

  // Short (48-bit) responses sit in the low bits with the upper field zeroed.
  function automatic logic [135:0] form_response(input resp_t rt, input logic [5:0] idx,
                                                 input logic [31:0] status,
                                                 input logic [31:0] ocr_v,
                                                 input logic [119:0] long_v);
    logic [135:0] f;
    f = '0;
    case (rt)
      RESP_R1: f[47:0] = {2'b00, idx, status, END_BYTE};
      RESP_R2: f       = {2'b00, R2_RESERVED, long_v, END_BYTE};
      RESP_R3: f[47:0] = {2'b00, R2_RESERVED, ocr_v, END_BYTE};
      default: f       = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/cmd_responder_if.sv
// Physical-layer command/response handshake between host and responder.
interface cmd_responder_if;
  logic         strobe_in;
  logic [39:0]  cmd_in;
  logic         ack_in;
  logic         ack_out;
  logic         strobe_out;
  logic [135:0] cmd_out;
  logic         idle_out;

  modport master (output strobe_in, cmd_in, ack_in,
                  input  ack_out, strobe_out, cmd_out, idle_out);
  modport slave  (input  strobe_in, cmd_in, ack_in,
                  output ack_out, strobe_out, cmd_out, idle_out);
endinterface

// File: rtl/cmd_delay_counter.sv
// Loadable down-counter that sticks at zero; load takes priority over decrement.
module cmd_delay_counter #(
  parameter int W = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/cmd_responder.sv
// Card-side command responder: accepts a 40-bit command, decodes it and,
// NCR cycles after acceptance, strobes an R1/R2/R3 response until acked or timed out.
module cmd_responder import cmd_pkg::*; #(
  parameter int NCR         = 2,
  parameter int ACK_TIMEOUT = 1024
) (
  input  logic            clock,
  input  logic            reset,
  cmd_responder_if.slave  phy,
  input  logic [31:0]     card_status,
  input  logic [31:0]     ocr,
  input  logic [119:0]    cid,
  input  logic [119:0]    csd,
  output logic            busy,
  output logic            cmd_received,
  output logic [5:0]      cmd_index_out,
  output logic [31:0]     cmd_argument_out,
  output logic            frame_error,
  output logic            resp_timeout
);

  localparam int CNT_MAX = (ACK_TIMEOUT > NCR) ? ACK_TIMEOUT : NCR;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  state_t         r_state, w_next;
  logic [39:0]    r_cmd;
  logic [5:0]     r_index;
  logic [31:0]    r_arg;
  logic [135:0]   r_resp;
  logic           r_ack, r_rcvd, r_ferr, r_tout;
  logic           w_load, w_dec, w_zero, w_tout, w_frame_ok, w_accept;
  logic [CNT_W-1:0] w_load_val;
  logic [5:0]     w_idx;
  resp_t          w_rtype;

  assign w_idx      = r_cmd[INDEX_MSB:INDEX_LSB];
  assign w_frame_ok = (r_cmd[START_MSB:START_LSB] == START_TX_OK);
  assign w_rtype    = resp_type_of(w_idx);
  assign w_accept   = (r_state == ST_IDLE) && phy.strobe_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Counter is shared: NCR-2 in DELAY, then ACK_TIMEOUT-1 for the RESPOND window.
  always_comb begin
    w_next     = r_state;
    w_load     = 1'b0;
    w_load_val = '0;
    w_dec      = 1'b0;
    w_tout     = 1'b0;
    case (r_state)
      ST_IDLE: if (phy.strobe_in) w_next = ST_DECODE;
      ST_DECODE: begin
        if (!w_frame_ok || (w_rtype == RESP_NONE)) begin
          w_next = ST_IDLE;
        end else begin
          w_next     = ST_DELAY;
          w_load     = 1'b1;
          w_load_val = CNT_W'(NCR - 2);
        end
      end
      ST_DELAY: begin
        if (w_zero) begin
          w_next     = ST_RESPOND;
          w_load     = 1'b1;
          w_load_val = CNT_W'(ACK_TIMEOUT - 1);
        end else begin
          w_dec = 1'b1;
        end
      end
      ST_RESPOND: begin
        if (phy.ack_in) begin
          w_next = ST_IDLE;
        end else if (w_zero) begin
          w_next = ST_IDLE;
          w_tout = 1'b1;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  cmd_delay_counter #(.W(CNT_W)) u_cnt (
    .clock      (clock),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_dec      (w_dec),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cmd   <= '0;
      r_index <= '0;
      r_arg   <= '0;
      r_resp  <= '0;
      r_ack   <= 1'b0;
      r_rcvd  <= 1'b0;
      r_ferr  <= 1'b0;
      r_tout  <= 1'b0;
    end else begin
      r_ack  <= w_accept;
      r_rcvd <= (r_state == ST_DECODE) && w_frame_ok;
      r_ferr <= (r_state == ST_DECODE) && !w_frame_ok;
      r_tout <= w_tout;
      if (w_accept) r_cmd <= phy.cmd_in;
      if ((r_state == ST_DECODE) && w_frame_ok) begin
        r_index <= w_idx;
        r_arg   <= r_cmd[ARG_MSB:ARG_LSB];
      end
      if ((r_state == ST_DECODE) && w_frame_ok && (w_rtype != RESP_NONE)) begin
        r_resp <= form_response(w_rtype, w_idx, card_status, ocr,
                                (w_idx == CMD2) ? cid : csd);
      end else if ((r_state == ST_RESPOND) && (w_next == ST_IDLE)) begin
        r_resp <= '0;
      end
    end
  end

  assign phy.ack_out    = r_ack;
  assign phy.strobe_out = (r_state == ST_RESPOND);
  assign phy.cmd_out    = r_resp;
  assign phy.idle_out   = (r_state == ST_IDLE);
  assign busy             = (r_state != ST_IDLE);
  assign cmd_received     = r_rcvd;
  assign cmd_index_out    = r_index;
  assign cmd_argument_out = r_arg;
  assign frame_error      = r_ferr;
  assign resp_timeout     = r_tout;

endmodule

// File: tb/tb_cmd_responder.sv
// Scoreboard bench for cmd_responder: expected frames are queued at command issue
// and popped when strobe_out is seen.
module tb_cmd_responder;

  localparam int NCR    = 2;
  localparam int ACK_TO = 8;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [31:0]  card_status = 32'h0000_0900;
  logic [31:0]  ocr = 32'h80FF_8000;
  logic [119:0] cid = {15{8'hA5}};
  logic [119:0] csd = 120'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32;
  logic         busy, cmd_received, frame_error, resp_timeout;
  logic [5:0]   cmd_index_out;
  logic [31:0]  cmd_argument_out;

  cmd_responder_if phy();

  cmd_responder #(.NCR(NCR), .ACK_TIMEOUT(ACK_TO)) dut (
    .clock            (clock),
    .reset            (reset),
    .phy              (phy),
    .card_status      (card_status),
    .ocr              (ocr),
    .cid              (cid),
    .csd              (csd),
    .busy             (busy),
    .cmd_received     (cmd_received),
    .cmd_index_out    (cmd_index_out),
    .cmd_argument_out (cmd_argument_out),
    .frame_error      (frame_error),
    .resp_timeout     (resp_timeout)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [135:0] exp_q[$];
  logic [135:0] exp_frame;

  function automatic logic [135:0] model_frame(input logic [5:0] idx);
    logic [135:0] f;
    f = '0;
    if (idx == 6'd2)                     f = {2'b00, 6'h3F, cid, 8'h01};
    else if (idx == 6'd9 || idx == 6'd10) f = {2'b00, 6'h3F, csd, 8'h01};
    else if (idx == 6'd41)               f[47:0] = {2'b00, 6'h3F, ocr, 8'h01};
    else                                 f[47:0] = {2'b00, idx, card_status, 8'h01};
    return f;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic [39:0] c);
    phy.cmd_in    = c;
    phy.strobe_in = 1'b1;
    if (c[39:38] == 2'b01 && c[37:32] != 6'd0 && c[37:32] != 6'd4 && c[37:32] != 6'd15)
      exp_q.push_back(model_frame(c[37:32]));
    tick();
    phy.strobe_in = 1'b0;
  endtask

  task automatic wait_strobe(input int budget, output int n);
    n = 0;
    while (phy.strobe_out !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    phy.strobe_in = 1'b0;
    phy.cmd_in    = '0;
    phy.ack_in    = 1'b0;
    #2;
    n_cmp++;
    if ({phy.ack_out, phy.strobe_out, busy, cmd_received, frame_error, resp_timeout} !== 6'b0 ||
        phy.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl: ack/strobe/busy/rcv/ferr/tout=%b idle=%b want 000000 1",
               {phy.ack_out, phy.strobe_out, busy, cmd_received, frame_error, resp_timeout}, phy.idle_out);
    end
    n_cmp++;
    if (phy.cmd_out !== '0 || cmd_index_out !== '0 || cmd_argument_out !== '0) begin
      n_fail++;
      $display("FAIL reset_data: cmd_out=%h idx=%h arg=%h want all 0", phy.cmd_out, cmd_index_out, cmd_argument_out);
    end
    phy.strobe_in = 1'b1;
    phy.cmd_in    = {2'b01, 6'd17, 32'h1};
    tick();
    n_cmp++;
    if (phy.ack_out !== 1'b0 || phy.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold: ack_out=%b idle_out=%b want 0 1", phy.ack_out, phy.idle_out);
    end
    phy.strobe_in = 1'b0;
    reset = 1'b1;
  endtask

  task automatic test_r1();
    logic [135:0] held;
    card_status = 32'h0000_0900;
    issue({2'b01, 6'd17, 32'h0000_0200});
    n_cmp++;
    if (phy.ack_out !== 1'b1 || phy.idle_out !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_ack: ack_out=%b idle_out=%b want 1 0", phy.ack_out, phy.idle_out);
    end
    tick();
    n_cmp++;
    if (cmd_received !== 1'b1 || cmd_index_out !== 6'd17 || cmd_argument_out !== 32'h200) begin
      n_fail++;
      $display("FAIL r1_rcv: rcv=%b idx=%0d arg=%h want 1 17 00000200", cmd_received, cmd_index_out, cmd_argument_out);
    end
    n_cmp++;
    if (phy.strobe_out !== 1'b0 || phy.ack_out !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_early: strobe=%b ack=%b want 0 0", phy.strobe_out, phy.ack_out);
    end
    tick();
    n_cmp++;
    if (phy.strobe_out !== 1'b1 || cmd_received !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_strobe: strobe=%b rcv=%b want 1 0", phy.strobe_out, cmd_received);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL r1_frame: nothing queued, got %h", phy.cmd_out);
    end else begin
      exp_frame = exp_q.pop_front();
      if (phy.cmd_out !== exp_frame) begin
        n_fail++;
        $display("FAIL r1_frame: got %h want %h", phy.cmd_out, exp_frame);
      end
    end
    n_cmp++;
    if (phy.cmd_out[47:0] !== 48'h11_0000_0900_01) begin
      n_fail++;
      $display("FAIL r1_literal: got %h want 110000090001", phy.cmd_out[47:0]);
    end
    held = phy.cmd_out;
    repeat (3) begin
      tick();
      n_cmp++;
      if (phy.strobe_out !== 1'b1 || phy.cmd_out !== held) begin
        n_fail++;
        $display("FAIL r1_hold: strobe=%b cmd_out=%h want 1 %h", phy.strobe_out, phy.cmd_out, held);
      end
    end
    phy.ack_in = 1'b1;
    tick();
    phy.ack_in = 1'b0;
    n_cmp++;
    if (phy.strobe_out !== 1'b0 || phy.cmd_out !== '0 || phy.idle_out !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL r1_release: strobe=%b cmd_out=%h idle=%b busy=%b want 0 0 1 0",
               phy.strobe_out, phy.cmd_out, phy.idle_out, busy);
    end
  endtask

  task automatic test_r2_cid();
    int n;
    issue({2'b01, 6'd2, 32'hDEAD_BEEF});
    wait_strobe(10, n);
    n_cmp++;
    if (n != NCR) begin
      n_fail++;
      $display("FAIL r2_latency: strobe after %0d cycles want %0d", n, NCR);
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL r2_frame: nothing queued, got %h", phy.cmd_out);
    end else begin
      exp_frame = exp_q.pop_front();
      if (phy.cmd_out !== exp_frame) begin
        n_fail++;
        $display("FAIL r2_frame: got %h want %h", phy.cmd_out, exp_frame);
      end
    end
    repeat (4) tick();
    n_cmp++;
    if (phy.cmd_out[133:128] !== 6'h3F || phy.cmd_out[127:8] !== cid || phy.strobe_out !== 1'b1) begin
      n_fail++;
      $display("FAIL r2_hold: rsv=%h payload=%h strobe=%b want 3f %h 1",
               phy.cmd_out[133:128], phy.cmd_out[127:8], phy.strobe_out, cid);
    end
    phy.ack_in = 1'b1;
    tick();
    phy.ack_in = 1'b0;
    n_cmp++;
    if (phy.idle_out !== 1'b1 || phy.strobe_out !== 1'b0) begin
      n_fail++;
      $display("FAIL r2_idle: idle=%b strobe=%b want 1 0", phy.idle_out, phy.strobe_out);
    end
  endtask

  task automatic test_no_resp();
    logic [5:0] idx_tab [3] = '{6'd0, 6'd15, 6'd4};
    int seen;
    for (int i = 0; i < 3; i++) begin
      issue({2'b01, idx_tab[i], 32'h0000_1000 + 32'(i)});
      tick();
      n_cmp++;
      if (cmd_received !== 1'b1 || cmd_index_out !== idx_tab[i] || phy.idle_out !== 1'b1) begin
        n_fail++;
        $display("FAIL noresp_%0d: rcv=%b idx=%0d idle=%b want 1 %0d 1",
                 idx_tab[i], cmd_received, cmd_index_out, phy.idle_out, idx_tab[i]);
      end
      seen = 0;
      repeat (5) begin
        tick();
        if (phy.strobe_out !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
        n_fail++;
        $display("FAIL noresp_strobe_%0d: strobe high %0d cycles want 0", idx_tab[i], seen);
      end
    end
  endtask

  task automatic test_frame_error();
    logic [1:0] st_tab [3] = '{2'b11, 2'b00, 2'b10};
    int seen;
    for (int i = 0; i < 3; i++) begin
      issue({st_tab[i], 6'd17, 32'hCAFE_0000});
      n_cmp++;
      if (phy.ack_out !== 1'b1) begin
        n_fail++;
        $display("FAIL ferr_ack_%0d: ack_out=%b want 1", i, phy.ack_out);
      end
      tick();
      n_cmp++;
      if (frame_error !== 1'b1 || cmd_received !== 1'b0 || phy.idle_out !== 1'b1 || cmd_index_out !== 6'd4) begin
        n_fail++;
        $display("FAIL ferr_%0d: ferr=%b rcv=%b idle=%b idx=%0d want 1 0 1 4",
                 i, frame_error, cmd_received, phy.idle_out, cmd_index_out);
      end
      seen = 0;
      repeat (4) begin
        tick();
        if (phy.strobe_out !== 1'b0 || frame_error !== 1'b0) seen++;
      end
      n_cmp++;
      if (seen != 0) begin
        n_fail++;
        $display("FAIL ferr_after_%0d: strobe/ferr high %0d cycles want 0", i, seen);
      end
    end
  endtask

  task automatic test_timeout();
    int n, hi;
    issue({2'b01, 6'd41, 32'h40FF_0000});
    wait_strobe(10, n);
    n_cmp++;
    if (n != NCR || exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL to_latency: strobe after %0d cycles queue=%0d want %0d nonempty", n, exp_q.size(), NCR);
    end else begin
      exp_frame = exp_q.pop_front();
      n_cmp++;
      if (phy.cmd_out !== exp_frame) begin
        n_fail++;
        $display("FAIL to_frame: got %h want %h", phy.cmd_out, exp_frame);
      end
    end
    hi = 1;
    phy.cmd_in    = {2'b01, 6'd7, 32'h7};
    phy.strobe_in = 1'b1;
    tick();
    phy.strobe_in = 1'b0;
    n_cmp++;
    if (phy.ack_out !== 1'b0) begin
      n_fail++;
      $display("FAIL to_second_ack: ack_out=%b want 0", phy.ack_out);
    end
    if (phy.strobe_out === 1'b1) hi++;
    n = 0;
    while (phy.strobe_out === 1'b1 && n < 30) begin
      tick();
      n++;
      if (phy.strobe_out === 1'b1) hi++;
    end
    n_cmp++;
    if (hi != ACK_TO) begin
      n_fail++;
      $display("FAIL to_window: strobe high %0d cycles want %0d", hi, ACK_TO);
    end
    n_cmp++;
    if (resp_timeout !== 1'b1 || phy.idle_out !== 1'b1 || cmd_index_out !== 6'd41) begin
      n_fail++;
      $display("FAIL to_pulse: tout=%b idle=%b idx=%0d want 1 1 41", resp_timeout, phy.idle_out, cmd_index_out);
    end
    tick();
    n_cmp++;
    if (resp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL to_width: tout=%b want 0", resp_timeout);
    end
  endtask

  task automatic test_ack_terminal();
    int n;
    issue({2'b01, 6'd13, 32'h0});
    wait_strobe(10, n);
    if (exp_q.size() != 0) exp_frame = exp_q.pop_front();
    n_cmp++;
    if (n != NCR || phy.cmd_out !== exp_frame) begin
      n_fail++;
      $display("FAIL term_frame: latency %0d got %h want %0d %h", n, phy.cmd_out, NCR, exp_frame);
    end
    repeat (ACK_TO - 1) tick();
    phy.ack_in = 1'b1;
    tick();
    phy.ack_in = 1'b0;
    n_cmp++;
    if (resp_timeout !== 1'b0 || phy.idle_out !== 1'b1 || phy.strobe_out !== 1'b0) begin
      n_fail++;
      $display("FAIL term_ack: tout=%b idle=%b strobe=%b want 0 1 0", resp_timeout, phy.idle_out, phy.strobe_out);
    end
  endtask

  task automatic test_ack_ignored();
    int n;
    phy.ack_in = 1'b1;
    repeat (3) tick();
    n_cmp++;
    if (phy.idle_out !== 1'b1 || phy.strobe_out !== 1'b0 || resp_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL ackidle: idle=%b strobe=%b tout=%b want 1 0 0", phy.idle_out, phy.strobe_out, resp_timeout);
    end
    issue({2'b01, 6'd9, 32'h9});
    wait_strobe(10, n);
    if (exp_q.size() != 0) exp_frame = exp_q.pop_front();
    n_cmp++;
    if (n != NCR || phy.cmd_out !== exp_frame) begin
      n_fail++;
      $display("FAIL ackearly: latency %0d got %h want %0d %h", n, phy.cmd_out, NCR, exp_frame);
    end
    tick();
    phy.ack_in = 1'b0;
    n_cmp++;
    if (phy.strobe_out !== 1'b0 || phy.idle_out !== 1'b1) begin
      n_fail++;
      $display("FAIL ackearly_rel: strobe=%b idle=%b want 0 1", phy.strobe_out, phy.idle_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] idx_tab [4] = '{6'd10, 6'd55, 6'd41, 6'd2};
    logic [31:0] arg;
    int n;
    for (int i = 0; i < 4; i++) begin
      arg = $urandom;
      card_status = $urandom;
      issue({2'b01, idx_tab[i], arg});
      wait_strobe(10, n);
      n_cmp++;
      if (n != NCR || exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL b2b_lat_%0d: latency %0d queue %0d want %0d nonempty", i, n, exp_q.size(), NCR);
      end else begin
        exp_frame = exp_q.pop_front();
        n_cmp++;
        if (phy.cmd_out !== exp_frame || cmd_argument_out !== arg) begin
          n_fail++;
          $display("FAIL b2b_frame_%0d: got %h arg %h want %h arg %h", i, phy.cmd_out, cmd_argument_out, exp_frame, arg);
        end
      end
      phy.ack_in = 1'b1;
      tick();
      phy.ack_in = 1'b0;
    end
  endtask

  task automatic test_reset_mid_respond();
    int n;
    issue({2'b01, 6'd17, 32'h55});
    wait_strobe(10, n);
    if (exp_q.size() != 0) exp_frame = exp_q.pop_front();
    n_cmp++;
    if (phy.strobe_out !== 1'b1 || phy.cmd_out !== exp_frame) begin
      n_fail++;
      $display("FAIL rst_pre: strobe=%b got %h want 1 %h", phy.strobe_out, phy.cmd_out, exp_frame);
    end
    #2;
    reset = 1'b0;
    #1;
    n_cmp++;
    if (phy.strobe_out !== 1'b0 || phy.cmd_out !== '0 || phy.idle_out !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async: strobe=%b cmd_out=%h idle=%b busy=%b want 0 0 1 0",
               phy.strobe_out, phy.cmd_out, phy.idle_out, busy);
    end
    n_cmp++;
    if (cmd_index_out !== '0 || cmd_argument_out !== '0) begin
      n_fail++;
      $display("FAIL rst_latch: idx=%h arg=%h want 0 0", cmd_index_out, cmd_argument_out);
    end
    tick();
    reset = 1'b1;
    issue({2'b01, 6'd3, 32'h33});
    n_cmp++;
    if (phy.ack_out !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first_cmd: ack_out=%b want 1", phy.ack_out);
    end
    wait_strobe(10, n);
    if (exp_q.size() != 0) exp_frame = exp_q.pop_front();
    n_cmp++;
    if (n != NCR || phy.cmd_out !== exp_frame) begin
      n_fail++;
      $display("FAIL rst_first_frame: latency %0d got %h want %0d %h", n, phy.cmd_out, NCR, exp_frame);
    end
    phy.ack_in = 1'b1;
    tick();
    phy.ack_in = 1'b0;
  endtask

  initial begin
    test_reset();
    test_r1();
    test_r2_cid();
    test_no_resp();
    test_frame_error();
    test_timeout();
    test_ack_terminal();
    test_ack_ignored();
    test_back_to_back();
    test_reset_mid_respond();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d responses never seen, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
